dmem_unit: RTL and testbench

Parametrised data-memory stage for the 32-bit processor: accepts load/store requests from the execute stage, performs byte/halfword/word accesses on an internal word-organised RAM, and returns the writeback value (loaded data or pass-through address/ALU result) after a configurable, fixed latency. It replaces the single-cycle combinational memory and writeback mux with an in-order pipelined unit that has a valid/ready handshake on both sides. It also adds sub-word access, sign extension and error flagging.

---
 rtl/dmem_unit_if.sv | 34 +++
 rtl/dmem_unit.sv | 114 +++++++++++
 tb/tb_dmem_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_unit_if.sv
// Request/response handshake bundle for the data-memory stage.
// master = execute/writeback side, slave = dmem_unit.
interface dmem_unit_if #(
    parameter int AWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              req_ms;
    logic [AWIDTH-1:0] req_addr;
    logic [AWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [AWIDTH-1:0] rsp_wd;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size,
        output req_unsigned, req_ms,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid,
        input  rsp_wd, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_unsigned, req_ms,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid,
        output rsp_wd, rsp_err
    );
endinterface

// File: rtl/dmem_unit.sv
// Pipelined data-memory stage: sub-word load/store on a word RAM,
// writeback mux and error flagging, fixed RD_LAT response latency.
module dmem_unit #(
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input logic       clk,
    input logic       rst_n,
    dmem_unit_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AWIDTH-1:0] LIMIT = AWIDTH'(4 * DEPTH);

    logic [31:0] mem_q [DEPTH];

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [AWIDTH-1:0] wd_q [RD_LAT];

    logic              stall;
    logic              accept;
    logic              wr_en;
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic              oor;
    logic              mis;
    logic              err_d;
    logic [3:0]        be;
    logic [31:0]       wrep;
    logic [31:0]       rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [AWIDTH-1:0] ext;
    logic [AWIDTH-1:0] wd_d;

    assign stall         = vld_q[RD_LAT-1] && !bus.rsp_ready;
    assign bus.req_ready = !stall;
    assign accept        = bus.req_valid && !stall && rst_n;
    assign idx           = bus.req_addr[IW+1:2];
    assign lane          = bus.req_addr[1:0];
    assign rword         = mem_q[idx];
    assign rbyte         = rword[{lane, 3'b000} +: 8];
    assign rhalf         = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        mis  = 1'b0;
        be   = 4'hf;
        wrep = bus.req_wdata;
        ext  = rword;
        unique case (bus.req_size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{bus.req_wdata[7:0]}};
                ext  = bus.req_unsigned ? {24'b0, rbyte}
                                        : {{24{rbyte[7]}}, rbyte};
            end
            2'b01: begin
                mis  = lane[0];
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{bus.req_wdata[15:0]}};
                ext  = bus.req_unsigned ? {16'b0, rhalf}
                                        : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                mis = |lane;
            end
        endcase
    end

    // Pass-through ALU results (ms=0 loads) are exempt from both checks.
    always_comb begin
        oor   = bus.req_addr >= LIMIT;
        err_d = (bus.req_ms || bus.req_we) && (oor || mis);
        wr_en = accept && bus.req_we && !err_d;
        if (err_d)
            wd_d = '0;
        else if (bus.req_we || !bus.req_ms)
            wd_d = bus.req_addr;
        else
            wd_d = ext;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++)
                wd_q[i] <= '0;
        end else if (!stall) begin
            vld_q[0] <= accept;
            err_q[0] <= accept && err_d;
            wd_q[0]  <= accept ? wd_d : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                wd_q[i]  <= wd_q[i-1];
            end
        end
    end

    assign bus.rsp_valid = vld_q[RD_LAT-1];
    assign bus.rsp_err   = err_q[RD_LAT-1];
    assign bus.rsp_wd    = wd_q[RD_LAT-1];
endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: vector table on an RD_LAT=1 instance,
// stall/reset sequences on an RD_LAT=3 instance.
module tb_dmem_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_unit_if #(.AWIDTH(32)) bus1 ();
    dmem_unit_if #(.AWIDTH(32)) bus3 ();

    dmem_unit #(.AWIDTH(32), .DEPTH(128), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    dmem_unit #(.AWIDTH(32), .DEPTH(128), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic        ms;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] wd;
        logic        err;
    } exp_t;

    vec_t tv[$];
    exp_t sb1[$];
    exp_t sb3[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz,
                       input logic uns, input logic ms,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input logic [31:0] ewd, input logic eerr);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.ms = ms;
        v.addr = a; v.wdata = wdat; v.exp_wd = ewd; v.exp_err = eerr;
        tv.push_back(v);
    endtask

    task automatic idle1();
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_size = 0;
        bus1.req_unsigned = 0; bus1.req_ms = 0;
        bus1.req_addr = 0; bus1.req_wdata = 0;
    endtask

    task automatic idle3();
        bus3.req_valid = 0; bus3.req_we = 0; bus3.req_size = 0;
        bus3.req_unsigned = 0; bus3.req_ms = 0;
        bus3.req_addr = 0; bus3.req_wdata = 0;
    endtask

    task automatic pop1(input int i);
        exp_t e;
        chk($sformatf("lat1_valid[%0d]", i), {31'b0, bus1.rsp_valid}, 1);
        e = sb1.pop_front();
        chk($sformatf("wd[%0d]", i), bus1.rsp_wd, e.wd);
        chk($sformatf("err[%0d]", i), {31'b0, bus1.rsp_err}, {31'b0, e.err});
    endtask

    // Back-to-back on dut1; each response must appear one cycle later.
    task automatic run_table();
        exp_t e;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            if (sb1.size() != 0) pop1(i - 1);
            bus1.req_valid    = 1;
            bus1.req_we       = tv[i].we;
            bus1.req_size     = tv[i].size;
            bus1.req_unsigned = tv[i].uns;
            bus1.req_ms       = tv[i].ms;
            bus1.req_addr     = tv[i].addr;
            bus1.req_wdata    = tv[i].wdata;
            #1;
            chk($sformatf("req_ready[%0d]", i), {31'b0, bus1.req_ready}, 1);
            e.wd = tv[i].exp_wd;
            e.err = tv[i].exp_err;
            sb1.push_back(e);
        end
        @(negedge clk);
        idle1();
        if (sb1.size() != 0) pop1(tv.size() - 1);
        @(negedge clk);
        chk("drain_valid", {31'b0, bus1.rsp_valid}, 0);
        tv.delete();
    endtask

    logic [31:0] st_addr [4];
    logic [31:0] st_data [4];

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        int k, got, first_acc, nstall, cnt;
        logic held;
        logic [31:0] prev_wd;
        exp_t e;

        st_addr[0] = 32'h100; st_data[0] = 32'hA1B2C3D4;
        st_addr[1] = 32'h104; st_data[1] = 32'h0F0F0F0F;
        st_addr[2] = 32'h108; st_data[2] = 32'h87654321;
        st_addr[3] = 32'h10C; st_data[3] = 32'hFEEDFACE;

        idle1(); idle3();
        bus1.rsp_ready = 1;
        bus3.rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        chk("rst_valid1", {31'b0, bus1.rsp_valid}, 0);
        chk("rst_wd1", bus1.rsp_wd, 0);
        chk("rst_err1", {31'b0, bus1.rsp_err}, 0);
        chk("rst_ready1", {31'b0, bus1.req_ready}, 1);
        chk("rst_valid3", {31'b0, bus3.rsp_valid}, 0);
        chk("rst_ready3", {31'b0, bus3.req_ready}, 1);

        add(1, 2, 0, 1, 32'h10, 32'hDEADBEEF, 32'h10, 0);
        add(0, 2, 0, 1, 32'h10, 0, 32'hDEADBEEF, 0);
        add(1, 0, 0, 1, 32'h13, 32'hAAAAAA80, 32'h13, 0);
        add(0, 0, 0, 1, 32'h13, 0, 32'hFFFFFF80, 0);
        add(0, 0, 1, 1, 32'h13, 0, 32'h00000080, 0);
        add(0, 2, 0, 1, 32'h10, 0, 32'h80ADBEEF, 0);
        add(1, 2, 0, 1, 32'h20, 32'h11223344, 32'h20, 0);
        add(1, 1, 0, 1, 32'h21, 32'h0000FFFF, 0, 1);
        add(0, 2, 0, 1, 32'h200, 0, 0, 1);
        add(0, 2, 0, 1, 32'h20, 0, 32'h11223344, 0);
        add(0, 2, 0, 0, 32'h12345678, 0, 32'h12345678, 0);
        add(0, 2, 0, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0);
        add(1, 1, 0, 1, 32'h22, 32'hABCD8001, 32'h22, 0);
        add(0, 2, 0, 1, 32'h20, 0, 32'h80013344, 0);
        add(0, 1, 0, 1, 32'h22, 0, 32'hFFFF8001, 0);
        add(0, 1, 1, 1, 32'h22, 0, 32'h00008001, 0);
        add(0, 1, 0, 1, 32'h20, 0, 32'h00003344, 0);
        add(0, 0, 0, 1, 32'h21, 0, 32'h00000033, 0);
        add(0, 2, 0, 1, 32'h12, 0, 0, 1);
        add(0, 1, 0, 1, 32'h13, 0, 0, 1);
        add(1, 2, 0, 1, 32'h1FC, 32'hCAFEF00D, 32'h1FC, 0);
        add(0, 0, 1, 1, 32'h1FF, 0, 32'h000000CA, 0);
        add(0, 3, 0, 1, 32'h1FC, 0, 32'hCAFEF00D, 0);
        add(1, 2, 0, 0, 32'h200, 32'h1, 0, 1);
        add(1, 0, 0, 1, 32'h1FF, 32'h55, 32'h1FF, 0);
        add(0, 2, 0, 1, 32'h1FC, 0, 32'h55FEF00D, 0);
        add(1, 2, 0, 0, 32'h40, 32'h77777777, 32'h40, 0);
        add(0, 2, 0, 1, 32'h40, 0, 32'h77777777, 0);
        add(1, 2, 0, 1, 32'h42, 32'h0, 0, 1);
        add(0, 2, 0, 1, 32'h40, 0, 32'h77777777, 0);
        run_table();

        // dut3: 4 stores, 4 loads, rsp_ready low for cycles 7 and 8
        k = 0; got = 0; first_acc = -1; nstall = 0;
        held = 0; prev_wd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus3.rsp_ready = !(c == 7 || c == 8);
            if (k < 8) begin
                bus3.req_valid    = 1;
                bus3.req_we       = (k < 4);
                bus3.req_size     = 2'b10;
                bus3.req_unsigned = 0;
                bus3.req_ms       = 1;
                bus3.req_addr     = st_addr[k % 4];
                bus3.req_wdata    = st_data[k % 4];
            end else begin
                idle3();
            end
            #1;
            if (bus3.rsp_valid && !bus3.rsp_ready) begin
                chk("stall_req_ready", {31'b0, bus3.req_ready}, 0);
                if (held) chk("stall_hold", bus3.rsp_wd, prev_wd);
                held = 1;
                prev_wd = bus3.rsp_wd;
                nstall++;
            end else begin
                held = 0;
            end
            if (bus3.rsp_valid && bus3.rsp_ready) begin
                if (sb3.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dup_rsp: got extra %h expected none",
                             bus3.rsp_wd);
                end else begin
                    if (got == 0) chk("lat3", c - first_acc, 3);
                    e = sb3.pop_front();
                    chk($sformatf("p3_wd[%0d]", got), bus3.rsp_wd, e.wd);
                    chk($sformatf("p3_err[%0d]", got),
                        {31'b0, bus3.rsp_err}, {31'b0, e.err});
                    got++;
                end
            end
            if (bus3.req_valid && bus3.req_ready) begin
                e.wd  = (k < 4) ? st_addr[k] : st_data[k - 4];
                e.err = 0;
                sb3.push_back(e);
                if (k == 0) first_acc = c;
                k++;
            end
            if (k == 8 && got == 8) break;
        end
        chk("p3_count", got, 8);
        chk("p3_stalls", nstall, 2);
        @(negedge clk);
        idle3();
        bus3.rsp_ready = 1;

        // two loads in flight, then reset; requests in reset cycle ignored
        @(negedge clk);
        bus3.req_valid = 1; bus3.req_size = 2'b10; bus3.req_ms = 1;
        bus3.req_addr = 32'h100;
        @(negedge clk);
        bus3.req_addr = 32'h104;
        @(negedge clk);
        rst_n = 0;
        bus3.req_we = 1; bus3.req_addr = 32'h100;
        bus3.req_wdata = 32'h0BADBAD0;
        bus1.req_valid = 1; bus1.req_we = 1; bus1.req_size = 2'b10;
        bus1.req_ms = 1; bus1.req_addr = 32'h1FC;
        bus1.req_wdata = 32'h0BADBAD0;
        @(negedge clk);
        rst_n = 1;
        idle1(); idle3();
        chk("inflight_rst_valid", {31'b0, bus3.rsp_valid}, 0);
        chk("inflight_rst_ready", {31'b0, bus3.req_ready}, 1);
        chk("rst2_valid1", {31'b0, bus1.rsp_valid}, 0);
        chk("rst2_wd1", bus1.rsp_wd, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus3.rsp_valid) cnt++;
        end
        chk("ghost_rsp", cnt, 0);

        add(0, 2, 0, 1, 32'h1FC, 0, 32'h55FEF00D, 0);
        add(0, 2, 0, 1, 32'h10, 0, 32'h80ADBEEF, 0);
        run_table();

        @(negedge clk);
        bus3.req_valid = 1; bus3.req_size = 2'b10; bus3.req_ms = 1;
        bus3.req_addr = 32'h100;
        @(negedge clk);
        idle3();
        cnt = 0;
        while (!bus3.rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("post_rst_valid3", {31'b0, bus3.rsp_valid}, 1);
        chk("post_rst_wd3", bus3.rsp_wd, 32'hA1B2C3D4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
